scan_sequencer: RTL and testbench



---
 rtl/scan_sequencer.sv | 156 +++++++++++++++
 tb/tb_scan_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Channel scan sequencer feeding a 3-to-8 one-hot decoder: steps sel through 0..last_ch,
// holding sel_en high for a programmable dwell with a fixed blanking gap before each channel.
module scan_sequencer #(
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic [2:0]         last_ch,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_en,
  output logic               ch_strobe,
  output logic               frame_done,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;

  localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  state_t               state_q, state_d;
  logic [2:0]           sel_q, sel_d;
  logic                 sel_en_q, sel_en_d;
  logic                 ch_strobe_q, ch_strobe_d;
  logic                 frame_done_q, frame_done_d;
  logic                 busy_q, busy_d;
  logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [2:0]           last_ch_q, last_ch_d;
  logic                 mode_cont_q, mode_cont_d;
  logic                 enter_ch;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    sel_en_d     = sel_en_q;
    ch_strobe_d  = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    blank_cnt_d  = blank_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    dwell_d      = dwell_q;
    last_ch_d    = last_ch_q;
    mode_cont_d  = mode_cont_q;
    enter_ch     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          last_ch_d   = last_ch;
          mode_cont_d = mode_cont;
          dwell_d     = (dwell == '0) ? DWELL_W'(1) : dwell;
          sel_d       = 3'd0;
          busy_d      = 1'b1;
          enter_ch    = 1'b1;
        end
      end
      BLANK: begin
        if (stop) begin
          state_d  = IDLE;
          sel_en_d = 1'b0;
          busy_d   = 1'b0;
        end else if (blank_cnt_q == '0) begin
          state_d     = DWELL;
          sel_en_d    = 1'b1;
          ch_strobe_d = 1'b1;
          dwell_cnt_d = dwell_q - DWELL_W'(1);
        end else begin
          blank_cnt_d = blank_cnt_q - BLANK_W'(1);
        end
      end
      DWELL: begin
        if (stop) begin
          state_d  = IDLE;
          sel_en_d = 1'b0;
          busy_d   = 1'b0;
        end else if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end else if (sel_q != last_ch_q) begin
          sel_d    = sel_q + 3'd1;
          enter_ch = 1'b1;
        end else begin
          frame_done_d = 1'b1;
          if (mode_cont_q) begin
            sel_d    = 3'd0;
            enter_ch = 1'b1;
          end else begin
            state_d  = IDLE;
            sel_en_d = 1'b0;
            busy_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        sel_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

    // Every new channel starts with its blanking gap, or directly in dwell when there is none.
    if (enter_ch) begin
      if (BLANK_CYC == 0) begin
        state_d     = DWELL;
        sel_en_d    = 1'b1;
        ch_strobe_d = 1'b1;
        dwell_cnt_d = dwell_d - DWELL_W'(1);
      end else begin
        state_d     = BLANK;
        sel_en_d    = 1'b0;
        blank_cnt_d = BLANK_LAST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 3'd0;
      sel_en_q     <= 1'b0;
      ch_strobe_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      blank_cnt_q  <= '0;
      dwell_cnt_q  <= '0;
      dwell_q      <= '0;
      last_ch_q    <= 3'd0;
      mode_cont_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sel_en_q     <= sel_en_d;
      ch_strobe_q  <= ch_strobe_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      blank_cnt_q  <= blank_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      dwell_q      <= dwell_d;
      last_ch_q    <= last_ch_d;
      mode_cont_q  <= mode_cont_d;
    end
  end

  assign sel        = sel_q;
  assign sel_en     = sel_en_q;
  assign ch_strobe  = ch_strobe_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: a slot-arithmetic reference model checked every cycle,
// directed frame scenarios with literal expectations, then a randomized phase.
module tb_scan_sequencer;

  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        mode_cont;
  logic [2:0]  last_ch;
  logic [15:0] dwell;
  logic [2:0]  sel;
  logic        sel_en;
  logic        ch_strobe;
  logic        frame_done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  scan_sequencer #(.DWELL_W(16), .BLANK_CYC(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mode_cont  (mode_cont),
    .last_ch    (last_ch),
    .dwell      (dwell),
    .sel        (sel),
    .sel_en     (sel_en),
    .ch_strobe  (ch_strobe),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: position n inside the frame gives channel n/S and slot offset n%S.
  bit         m_active = 1'b0;
  bit         m_mode   = 1'b0;
  int         m_n = 0;
  int         m_L = 0;
  int         m_D = 1;
  int         m_S = B + 1;
  logic [2:0] e_sel    = 3'd0;
  logic       e_en     = 1'b0;
  logic       e_strobe = 1'b0;
  logic       e_fd     = 1'b0;
  logic       e_busy   = 1'b0;

  always @(posedge clk) begin
    e_fd = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      e_sel    = 3'd0;
    end else if (!m_active) begin
      if (start && !stop) begin
        m_active = 1'b1;
        m_L      = int'(last_ch);
        m_D      = (dwell == 16'd0) ? 1 : int'(dwell);
        m_mode   = mode_cont;
        m_S      = B + m_D;
        m_n      = 0;
      end
    end else if (stop) begin
      m_active = 1'b0;
    end else begin
      m_n++;
      if (m_n == (m_L + 1) * m_S) begin
        e_fd = 1'b1;
        if (m_mode) m_n = 0;
        else        m_active = 1'b0;
      end
    end
    if (m_active) begin
      e_sel    = 3'(m_n / m_S);
      e_en     = (m_n % m_S) >= B;
      e_strobe = (m_n % m_S) == B;
      e_busy   = 1'b1;
    end else begin
      e_en     = 1'b0;
      e_strobe = 1'b0;
      e_busy   = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT against the model on every cycle, sampled mid-cycle.
  always @(negedge clk) begin
    checkOutput("model_sel",        32'(sel),        32'(e_sel));
    checkOutput("model_sel_en",     32'(sel_en),     32'(e_en));
    checkOutput("model_ch_strobe",  32'(ch_strobe),  32'(e_strobe));
    checkOutput("model_frame_done", 32'(frame_done), 32'(e_fd));
    checkOutput("model_busy",       32'(busy),       32'(e_busy));
  end

  task automatic applyStimulus(input logic s, input logic p, input logic m, input logic [2:0] l,
                               input logic [15:0] d);
    start     = s;
    stop      = p;
    mode_cont = m;
    last_ch   = l;
    dwell     = d;
  endtask

  task automatic checkIdleZero(input string name);
    checkOutput({name, "_sel"},    32'(sel),        32'd0);
    checkOutput({name, "_en"},     32'(sel_en),     32'd0);
    checkOutput({name, "_strobe"}, 32'(ch_strobe),  32'd0);
    checkOutput({name, "_fd"},     32'(frame_done), 32'd0);
    checkOutput({name, "_busy"},   32'(busy),       32'd0);
  endtask

  // Single frame B=2, dwell=3, last_ch=2; optionally pokes start/last_ch mid-frame.
  task automatic runSingleFrame(input bit poke);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 16'd3);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      case (c)
        0:  checkOutput("sf_c0_busy", 32'(busy), 32'd1);
        2:  begin
              checkOutput("sf_c2_en",     32'(sel_en),    32'd1);
              checkOutput("sf_c2_strobe", 32'(ch_strobe), 32'd1);
            end
        5:  begin
              checkOutput("sf_c5_en",  32'(sel_en), 32'd0);
              checkOutput("sf_c5_sel", 32'(sel),    32'd1);
            end
        7:  checkOutput("sf_c7_strobe", 32'(ch_strobe), 32'd1);
        12: begin
              checkOutput("sf_c12_sel",    32'(sel),       32'd2);
              checkOutput("sf_c12_strobe", 32'(ch_strobe), 32'd1);
            end
        14: checkOutput("sf_c14_en", 32'(sel_en), 32'd1);
        15: begin
              checkOutput("sf_c15_fd",   32'(frame_done), 32'd1);
              checkOutput("sf_c15_busy", 32'(busy),       32'd0);
              checkOutput("sf_c15_sel",  32'(sel),        32'd2);
            end
        16: checkOutput("sf_c16_fd", 32'(frame_done), 32'd0);
        default: ;
      endcase
      if (poke && c == 6) begin
        start   = 1'b1;
        last_ch = 3'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom));
    repeat (3) @(negedge clk);
    checkIdleZero("reset");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd5, 16'd4);
    repeat (3) @(negedge clk);
    checkIdleZero("idle_hold");

    runSingleFrame(1'b0);
    runSingleFrame(1'b1);

    // Abort in cycle 8 of the single frame.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 16'd3);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c == 8) checkOutput("ab_c8_en", 32'(sel_en), 32'd1);
      if (c == 9) begin
        checkOutput("ab_c9_en",   32'(sel_en), 32'd0);
        checkOutput("ab_c9_busy", 32'(busy),   32'd0);
        checkOutput("ab_c9_sel",  32'(sel),    32'd1);
      end
      if (c > 9) checkOutput("ab_no_fd", 32'(frame_done), 32'd0);
      stop = (c == 8);
      @(negedge clk);
    end

    // Continuous frames, last_ch=7, dwell=1.
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd7, 16'd1);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 50; c++) begin
      if (c == 23) checkOutput("ct_c23_sel", 32'(sel), 32'd7);
      if (c == 24) begin
        checkOutput("ct_c24_fd",  32'(frame_done), 32'd1);
        checkOutput("ct_c24_sel", 32'(sel),        32'd0);
      end
      if (c == 48) checkOutput("ct_c48_fd", 32'(frame_done), 32'd1);
      checkOutput("ct_busy", 32'(busy), 32'd1);
      stop = (c == 50);
      @(negedge clk);
    end
    stop = 1'b0;
    checkOutput("ct_stop_busy", 32'(busy), 32'd0);

    // dwell=0 behaves as 1.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("d0_c2_en", 32'(sel_en), 32'd1);
    @(negedge clk);
    checkOutput("d0_c3_fd", 32'(frame_done), 32'd1);
    checkOutput("d0_c3_en", 32'(sel_en),     32'd0);

    // start and stop together: nothing happens.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 16'd2);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd3, 16'd2);
    checkOutput("ss_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);

    // Reset in cycle 6, then the single frame must replay exactly.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 16'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("rs_c6_sel", 32'(sel), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkIdleZero("mid_reset");
    rst = 1'b0;
    runSingleFrame(1'b0);

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0), 1'($urandom),
                    3'($urandom), ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 5)));
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
